sr_window_ctrl: RTL
===================

SR_WINDOW_CTRL -- requirements
Module: sr_window_ctrl

Interface
REQ-001 SHALL have parameter ROW_WIDTH, default 256; pixels per image row, legal range 3..511.
REQ-002 SHALL have parameter ROWS, default 256; rows per frame, legal range 1..511.
REQ-003 SHALL have parameter STRIDE, default 2; down-sampling step between emitted windows, legal range 1..4.
REQ-004 SHALL have port clk, input, 1 bit; single clock, all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit; begins a frame when sampled high in IDLE.
REQ-007 SHALL have port pix_in, input, 8 bits; incoming pixel.
REQ-008 SHALL have port pix_valid, input, 1 bit; pix_in holds a valid pixel.
REQ-009 SHALL have port pix_ready, output, 1 bit; the block can accept a pixel this cycle.
REQ-010 SHALL have port sr_data, output, 8 bits; registered pixel driven to the SR1 input of the 3-stage shift chain.
REQ-011 SHALL have port sr_shift, output, 1 bit; one-cycle pulse marking a new sr_data value, so the chain shifts once.
REQ-012 SHALL have port win_valid, output, 1 bit; the SR1..SR3 window is settled and ready for the down-sampling datapath.
REQ-013 SHALL have port win_ack, input, 1 bit; the datapath has consumed the window.
REQ-014 SHALL have port col_idx, output, 9 bits; pixels accepted in the current row.
REQ-015 SHALL have port row_idx, output, 9 bits; rows completed in the current frame.
REQ-016 SHALL have port row_done, output, 1 bit; one-cycle pulse at the end of each row.
REQ-017 SHALL have port frame_done, output, 1 bit; one-cycle pulse at the end of the frame.
REQ-018 SHALL have port busy, output, 1 bit; high in every state except IDLE.

Function
REQ-019 SHALL implement states IDLE, RUN, SETTLE, WAIT_ACK and ROW_END; all outputs are registered or decoded from state only.
REQ-020 SHALL move IDLE->RUN when start=1 and clear col_idx, row_idx and the internal fill count; start SHALL be ignored in all other states.
REQ-021 SHALL drive pix_ready=1 only in RUN; an accept is pix_valid & pix_ready.
REQ-022 SHALL, on an accept in cycle t, drive sr_data=pix_in and sr_shift=1 during t+1, increment col_idx, and increment the fill count saturating at 3.
REQ-023 SHALL treat an accept as qualifying when, after the increment, fill=3 and (col_idx-3) mod STRIDE = 0.
REQ-024 SHALL move to SETTLE on a qualifying accept; SETTLE lasts exactly 1 cycle, then moves to WAIT_ACK.
REQ-025 SHALL hold win_valid=1 throughout WAIT_ACK; win_valid SHALL rise 2 cycles after the accepting edge.
REQ-026 SHALL leave WAIT_ACK on the first edge with win_ack=1, going to ROW_END if col_idx=ROW_WIDTH and to RUN otherwise; win_ack SHALL be ignored outside WAIT_ACK.
REQ-027 SHALL go straight to ROW_END on a non-qualifying accept with col_idx=ROW_WIDTH; otherwise a non-qualifying accept stays in RUN, allowing back-to-back accepts.
REQ-028 SHALL spend 1 cycle in ROW_END, pulsing row_done, incrementing row_idx and clearing col_idx and fill; windows never span rows.
REQ-029 SHALL pulse frame_done together with row_done and go to IDLE when the incremented row_idx=ROWS, and go to RUN otherwise.
REQ-030 SHALL emit floor((ROW_WIDTH-3)/STRIDE)+1 windows per row.
REQ-031 SHALL keep sr_shift at 0 except in the cycle after an accept; sr_data SHALL hold its last value.

Reset
REQ-032 SHALL, while rst_n=0 and asynchronously, force state IDLE, with sr_data, col_idx and row_idx at 0 and pix_ready, sr_shift, win_valid, row_done, frame_done and busy at 0.
REQ-033 SHALL abandon any in-progress frame or pending window on reset; after release, the block waits for start.

Verification
REQ-034 SHALL be checked with ROW_WIDTH=8, STRIDE=2, ROWS=2, pix_valid=1 and win_ack=1 constantly: 3 windows per row at col_idx 3, 5 and 7; 2 row_done pulses; 1 frame_done; then IDLE with busy=0.
REQ-035 SHALL be checked with pixels 0x10, 0x20, 0x30 accepted back-to-back: sr_shift high for 3 consecutive cycles carrying 0x10, 0x20, 0x30; win_valid rises 2 cycles after the third accept; pix_ready=0 during SETTLE and WAIT_ACK.
REQ-036 SHALL be checked with win_ack held low for 5 cycles: win_valid stays 1 and there are no accepts or sr_shift pulses; the state exits 1 cycle after win_ack=1.
REQ-037 SHALL be checked with STRIDE=1, ROW_WIDTH=4 and one gap cycle between pixels: windows appear at col_idx 3 and 4, then row_done follows the last window's ack.
REQ-038 SHALL be checked with rst_n asserted in WAIT_ACK mid-row: all outputs reach their reset values immediately, and a new start restarts at col_idx=0 and row_idx=0 with fill rebuilt from empty.
REQ-039 SHALL be checked with start pulsed while busy=1: no effect on col_idx, row_idx or state.

Source files
------------

// File: rtl/sr_window_ctrl.sv
// sr_window_ctrl
//   Streams pixels of a frame into an external 3-stage shift chain (SR1..SR3)
//   and tells the down-sampling datapath when the chain holds a window worth
//   processing. Every STRIDE-th position with a full 3-pixel chain produces a
//   window. The controller then stalls intake until the datapath acknowledges
//   that window. Windows never cross a row boundary.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : begins a frame when sampled high while idle
//   pix_in     : incoming 8-bit pixel
//   pix_valid  : pix_in holds a valid pixel
//   pix_ready  : a pixel can be accepted this cycle
//   sr_data    : registered pixel feeding SR1 of the shift chain
//   sr_shift   : one-cycle pulse, the chain shifts in sr_data
//   win_valid  : SR1..SR3 hold a settled window awaiting win_ack
//   win_ack    : the datapath has consumed the window
//   col_idx    : pixels accepted in the current row
//   row_idx    : rows completed in the current frame
//   row_done   : one-cycle pulse at the end of each row
//   frame_done : one-cycle pulse at the end of the frame
//   busy       : high whenever a frame is in progress
module sr_window_ctrl #(
  parameter int ROW_WIDTH = 256,
  parameter int ROWS      = 256,
  parameter int STRIDE    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [7:0] sr_data,
  output logic       sr_shift,
  output logic       win_valid,
  input  logic       win_ack,
  output logic [8:0] col_idx,
  output logic [8:0] row_idx,
  output logic       row_done,
  output logic       frame_done,
  output logic       busy
);

  localparam logic [8:0] LP_ROW_WIDTH = 9'(ROW_WIDTH);
  localparam logic [8:0] LP_ROWS      = 9'(ROWS);
  localparam logic [8:0] LP_STRIDE    = 9'(STRIDE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SETTLE,
    S_WAIT_ACK,
    S_ROW_END
  } state_t;

  state_t     r_state;
  state_t     w_stateNext;

  logic [7:0] r_srData;
  logic       r_srShift;
  logic [8:0] r_colIdx;
  logic [8:0] r_rowIdx;
  logic [1:0] r_fill;
  logic       r_rowDone;
  logic       r_frameDone;

  logic       w_accept;
  logic [8:0] w_colNext;
  logic [8:0] w_colOffset;
  logic [1:0] w_fillNext;
  logic       w_qualify;
  logic [8:0] w_rowNext;
  logic       w_lastRow;

  assign w_accept    = pix_valid && (r_state == S_RUN);
  assign w_colNext   = r_colIdx + 9'd1;
  assign w_fillNext  = (r_fill == 2'd3) ? 2'd3 : (r_fill + 2'd1);
  // Only evaluated once the chain is full, so col_idx is at least 3 here
  // and the subtraction cannot wrap in a way that matters.
  assign w_colOffset = w_colNext - 9'd3;
  assign w_qualify   = (w_fillNext == 2'd3) && ((w_colOffset % LP_STRIDE) == 9'd0);
  assign w_rowNext   = r_rowIdx + 9'd1;
  assign w_lastRow   = (w_rowNext == LP_ROWS);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode. A qualifying accept always takes the window path, even
  // on the last column; the row end then follows the window's acknowledge.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_stateNext = S_RUN;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          if (w_qualify) begin
            w_stateNext = S_SETTLE;
          end else if (w_colNext == LP_ROW_WIDTH) begin
            w_stateNext = S_ROW_END;
          end
        end
      end
      S_SETTLE: begin
        w_stateNext = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (win_ack) begin
          w_stateNext = (r_colIdx == LP_ROW_WIDTH) ? S_ROW_END : S_RUN;
        end
      end
      S_ROW_END: begin
        w_stateNext = w_lastRow ? S_IDLE : S_RUN;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Datapath registers. row_done/frame_done are set on the edge that enters
  // ROW_END so they are high exactly during that state; the row counter and
  // column clear happen on the edge that leaves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_srData    <= 8'd0;
      r_srShift   <= 1'b0;
      r_colIdx    <= 9'd0;
      r_rowIdx    <= 9'd0;
      r_fill      <= 2'd0;
      r_rowDone   <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_srShift   <= w_accept;
      r_rowDone   <= (w_stateNext == S_ROW_END);
      r_frameDone <= (w_stateNext == S_ROW_END) && w_lastRow;
      if (w_accept) begin
        r_srData <= pix_in;
        r_colIdx <= w_colNext;
        r_fill   <= w_fillNext;
      end
      if ((r_state == S_IDLE) && start) begin
        r_colIdx <= 9'd0;
        r_rowIdx <= 9'd0;
        r_fill   <= 2'd0;
      end
      if (r_state == S_ROW_END) begin
        r_rowIdx <= w_rowNext;
        r_colIdx <= 9'd0;
        r_fill   <= 2'd0;
      end
    end
  end

  assign pix_ready  = (r_state == S_RUN);
  assign win_valid  = (r_state == S_WAIT_ACK);
  assign busy       = (r_state != S_IDLE);
  assign sr_data    = r_srData;
  assign sr_shift   = r_srShift;
  assign col_idx    = r_colIdx;
  assign row_idx    = r_rowIdx;
  assign row_done   = r_rowDone;
  assign frame_done = r_frameDone;

endmodule
